mips_instr_encoder: RTL and testbench

Inverse of the processor's instruction decoder. Accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit MIPS instruction words. Buffers the words in a small FIFO and streams them out with a sequential word address for loading instruction memory. Covers the supported subset: R-type, addi and addiu.

---
 rtl/mips_instr_encoder_if.sv | 44 ++++
 rtl/mips_instr_encoder.sv | 111 +++++++++++
 tb/tb_mips_instr_encoder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_instr_encoder_if
// Purpose  : Request/stream/status bundle between a producer and the encoder.
// Revision : 1.0  initial release
// ============================================================================
interface mips_instr_encoder_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic              in_itype;
    logic [3:0]        in_aluop;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_illegal;
    logic [7:0]        err_count;
    logic [CNT_W-1:0]  fifo_count;

    modport slave (
        input  in_valid, in_itype, in_aluop, in_rs, in_rt, in_rd, in_shamt, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_addr,
        output err_illegal, err_count, fifo_count
    );

    modport master (
        output in_valid, in_itype, in_aluop, in_rs, in_rt, in_rd, in_shamt, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_addr,
        input  err_illegal, err_count, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_instr_encoder
// Purpose  : Packs decoded fields into MIPS words, buffers and streams them.
// Revision : 1.0  initial release
// ============================================================================
module mips_instr_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_instr_encoder_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_pulse_q, err_pulse_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              accept;
    logic              push;
    logic              pop;
    logic              not_full;
    logic              not_empty;

    // Only addi (0000) and addiu (0001) exist in the I-type subset.
    always_comb begin
        enc_legal = !bus.in_itype || (bus.in_aluop[3:1] == 3'b000);
        if (bus.in_itype) begin
            enc_word = {5'b00100, bus.in_aluop[0], bus.in_rs, bus.in_rt, bus.in_imm};
        end else begin
            enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt,
                        2'b10, bus.in_aluop};
        end
    end

    always_comb begin
        not_full    = (count_q < CNT_W'(DEPTH));
        not_empty   = (count_q != '0);
        accept      = bus.in_valid && not_full;
        push        = accept && enc_legal;
        pop         = not_empty && bus.out_ready;

        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        addr_d      = addr_q;
        err_pulse_d = accept && !enc_legal;
        err_cnt_d   = err_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = enc_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            addr_d   = addr_q + ADDR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (err_pulse_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= BASE_ADDR;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Every output comes from registered state, so in_* never reaches out_* combinationally.
    always_comb begin
        bus.in_ready    = (count_q < CNT_W'(DEPTH));
        bus.out_valid   = (count_q != '0);
        bus.out_instr   = (count_q != '0) ? mem_q[rd_ptr_q] : 32'd0;
        bus.out_addr    = addr_q;
        bus.err_illegal = err_pulse_q;
        bus.err_count   = err_cnt_q;
        bus.fifo_count  = count_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_instr_encoder
// Purpose  : Randomised bench with a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_instr_encoder;
    localparam int         DEPTH  = 4;
    localparam int         ADDR_W = 8;
    localparam logic [7:0] BASE   = 8'hFE;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mips_instr_encoder_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    mips_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the field layout, built with weighted sums.
    function automatic logic [31:0] menc(input logic it, input logic [3:0] op,
                                         input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [15:0] imm);
        longint unsigned w;
        if (!it) w = longint'(rs) * (2**21) + longint'(rt) * (2**16) + longint'(rd) * (2**11)
                   + longint'(sh) * 64 + 32 + longint'(op);
        else     w = (8 + longint'(op)) * (2**26) + longint'(rs) * (2**21)
                   + longint'(rt) * (2**16) + longint'(imm);
        return w[31:0];
    endfunction

    logic [31:0] mq[$];
    logic [7:0]  m_addr;
    logic        m_pulse;
    int          m_errcnt;
    bit          m_live = 0;

    always @(negedge clk) begin
        bit          acc, lg, pp;
        logic [31:0] ew;
        if (m_live) begin
            chk("out_valid",   bus.out_valid,   32'(mq.size() != 0));
            chk("in_ready",    bus.in_ready,    32'(mq.size() < DEPTH));
            chk("fifo_count",  bus.fifo_count,  32'(mq.size()));
            chk("out_instr",   bus.out_instr,   (mq.size() != 0) ? mq[0] : 32'd0);
            chk("out_addr",    bus.out_addr,    32'(m_addr));
            chk("err_illegal", bus.err_illegal, 32'(m_pulse));
            chk("err_count",   bus.err_count,   32'(m_errcnt));
        end
        if (reset) begin
            mq.delete();
            m_addr   = BASE;
            m_pulse  = 1'b0;
            m_errcnt = 0;
            m_live   = 1;
        end else if (m_live) begin
            acc = bus.in_valid && (mq.size() < DEPTH);
            lg  = !bus.in_itype || (bus.in_aluop < 4'd2);
            pp  = (mq.size() != 0) && bus.out_ready;
            ew  = menc(bus.in_itype, bus.in_aluop, bus.in_rs, bus.in_rt,
                       bus.in_rd, bus.in_shamt, bus.in_imm);
            if (pp) begin
                void'(mq.pop_front());
                m_addr = m_addr + 8'd1;
            end
            if (acc && lg) mq.push_back(ew);
            m_pulse = acc && !lg;
            if (m_pulse && m_errcnt < 255) m_errcnt++;
        end
    end

    task automatic set_req(input logic it, input logic [3:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                           input logic [15:0] imm);
        bus.in_itype = it;
        bus.in_aluop = op;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_rd    = rd;
        bus.in_shamt = sh;
        bus.in_imm   = imm;
    endtask

    task automatic send(input logic it, input logic [3:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [15:0] imm);
        bit ok;
        int n;
        @(posedge clk); #1;
        set_req(it, op, rs, rt, rd, sh, imm);
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.out_valid) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] exp_w [3];
    logic [7:0]  exp_a [3];

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0);
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_fifo_count", bus.fifo_count, 32'd0);
        chk("rst_out_valid",  bus.out_valid,  32'd0);
        chk("rst_in_ready",   bus.in_ready,   32'd1);
        chk("rst_out_addr",   bus.out_addr,   32'h0000_00FE);
        chk("rst_out_instr",  bus.out_instr,  32'd0);

        // R-type add, visible the cycle after accept
        @(posedge clk); #1 bus.out_ready = 1'b1;
        send(1'b0, 4'b0000, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0);
        @(negedge clk);
        chk("add_valid", bus.out_valid, 32'd1);
        chk("add_instr", bus.out_instr, 32'h0022_1820);
        chk("add_addr",  bus.out_addr,  32'h0000_00FE);

        // addi / addiu / sub in order, crossing the address wrap
        do_reset();
        bus.out_ready = 1'b0;
        send(1'b1, 4'b0000, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005);
        send(1'b1, 4'b0001, 5'd0, 5'd4, 5'd0, 5'd0, 16'hFFFF);
        send(1'b0, 4'b0010, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0);
        exp_w = '{32'h2022_0005, 32'h2404_FFFF, 32'h0085_3022};
        exp_a = '{8'hFE, 8'hFF, 8'h00};
        @(negedge clk);
        chk("seq_count", bus.fifo_count, 32'd3);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("seq_instr", bus.out_instr, exp_w[i]);
            chk("seq_addr",  bus.out_addr,  32'(exp_a[i]));
        end
        @(posedge clk); #1 bus.out_ready = 1'b0;

        // Backpressure: four fill the FIFO, the fifth waits
        for (int i = 0; i < 4; i++)
            send(1'b0, 4'(i + 3), 5'(i + 1), 5'(i + 2), 5'(i + 3), 5'(i), 16'd0);
        @(negedge clk);
        chk("full_in_ready", bus.in_ready,   32'd0);
        chk("full_count",    bus.fifo_count, 32'd4);
        fork
            send(1'b1, 4'b0001, 5'd9, 5'd10, 5'd0, 5'd0, 16'h1234);
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        wait_empty();

        // Illegal I-type: dropped, pulses, counts, saturates
        send(1'b1, 4'b0010, 5'd1, 5'd2, 5'd3, 5'd4, 16'h00AA);
        @(negedge clk);
        chk("ill_pulse", bus.err_illegal, 32'd1);
        chk("ill_count", bus.err_count,   32'd1);
        chk("ill_empty", bus.out_valid,   32'd0);
        @(negedge clk);
        chk("ill_pulse_end", bus.err_illegal, 32'd0);
        @(posedge clk); #1;
        set_req(1'b1, 4'b0111, 5'd3, 5'd3, 5'd3, 5'd3, 16'h0);
        bus.in_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("ill_saturate", bus.err_count, 32'd255);

        // Randomised traffic with alternating backpressure phases
        for (int i = 0; i < 2000; i++) begin
            logic       it;
            logic [3:0] op;
            @(posedge clk); #1;
            it = 1'($urandom_range(0, 1));
            if (it) op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(2, 15));
            else    op = 4'($urandom_range(0, 15));
            set_req(it, op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = (((i / 200) % 2) == 0) ? ($urandom_range(0, 3) != 0)
                                                   : ($urandom_range(0, 3) == 0);
        end
        @(posedge clk); #1 bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_empty();

        // Reset while holding 3 entries with a push and pop pending
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(1'b0, 4'd0, 5'(i), 5'(i), 5'(i), 5'(i), 16'd0);
        @(posedge clk); #1;
        set_req(1'b1, 4'b0000, 5'd7, 5'd8, 5'd0, 5'd0, 16'h7777);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        @(posedge clk); #1;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("mid_rst_count",    bus.fifo_count, 32'd0);
        chk("mid_rst_valid",    bus.out_valid,  32'd0);
        chk("mid_rst_addr",     bus.out_addr,   32'h0000_00FE);
        chk("mid_rst_errcount", bus.err_count,  32'd0);
        chk("mid_rst_ready",    bus.in_ready,   32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
